mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-low.
REQ-003 cpu_req / cpu_we  input  1/1  CPU access request; write when cpu_we=1, read otherwise.
REQ-004 cpu_addr / cpu_wdata  input  8/8  CPU address and write data, held stable while cpu_req=1 and cpu_gnt=0.
REQ-005 cpu_gnt / cpu_stall  output  1/1  CPU access accepted this cycle; cpu_stall = cpu_req AND NOT cpu_gnt.
REQ-006 cpu_rvalid / cpu_rdata  output  1/8  CPU read data valid, and its data.
REQ-007 dbg_req / dbg_we / dbg_addr / dbg_wdata  input  1/1/8/8  debug/loader port; same meaning and rules as the CPU port.
REQ-008 dbg_gnt / dbg_rvalid / dbg_rdata  output  1/1/8  debug port grant, read valid and read data.
REQ-009 mem_en / mem_we  output  1/1  memory access strobe and write strobe.
REQ-010 mem_addr / mem_wdata  output  8/8  memory address and write data.
REQ-011 mem_rdata  input  8  registered memory read data, valid one cycle after the mem_en read.

Function
REQ-012 Access is accepted in the cycle where req=1 and gnt=1 on a port. Grant is combinational from req and the registered arbitration state, with zero-cycle latency.
REQ-013 At most one gnt is high per cycle. gnt=0 whenever the matching req=0.
REQ-014 In the accept cycle: mem_en=1, mem_we=winner we, mem_addr and mem_wdata = winner payload. With no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-015 Read accepted at cycle N: the winner's rvalid=1 at N+1, rdata=mem_rdata at N+1. A write never raises rvalid.
REQ-016 When rvalid=0, rdata SHALL be 8'h00.
REQ-017 Owner FSM, registered, with states IDLE/CPU/DBG recording the last-cycle winner. Transitions:
- no grant -> IDLE
- cpu_gnt -> CPU
- dbg_gnt -> DBG
REQ-018 Default policy is fixed priority, DBG over CPU.
REQ-019 Starvation guard: a 2-bit burst counter counts consecutive dbg grants while cpu_req=1.
- At count 3 (4th consecutive DBG win), the next contested cycle grants CPU and the counter clears.
- The counter also clears on any CPU grant or any cycle with cpu_req=0.
REQ-020 Either port may issue back-to-back accesses, one per cycle, by holding req high.
REQ-021 A read accepted at N and another access at N+1 are legal. rvalid for N routes by the registered read owner, independent of the N+1 winner.
REQ-022 A request dropped before grant is abandoned, with no memory side effect.

Reset
REQ-023 When rst=0 at a clock edge, the following clear at that edge:
- owner=IDLE
- burst counter=0
- round-robin pointer=CPU
- read-owner/rvalid pipeline=0
REQ-024 While rst=0 all gnt, mem_en, mem_we, stall and rvalid outputs SHALL be 0, and all data/address outputs 8'h00.
REQ-025 A read accepted in the cycle before reset assertion SHALL NOT produce rvalid after reset.

Configuration
REQ-026 Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: fixed priority and the burst counter are removed. When both ports request, the port not granted in the most recent contested cycle wins. The pointer starts at CPU after reset, so DBG wins the first contest.
- Undefined: REQ-018/019 apply.
- Uncontested behaviour is identical in both builds.

Verification
REQ-027 Single read: cpu_req=1, cpu_we=0, addr=8'h12, mem_rdata=8'hA5 next cycle -> cpu_gnt=1 and mem_en=1 same cycle; cpu_rvalid=1, cpu_rdata=8'hA5 one cycle later; dbg_rvalid stays 0.
REQ-028 Contention, fixed build: both req high for 6 cycles -> grant sequence DBG,DBG,DBG,DBG,CPU,DBG; cpu_stall=1 in exactly the 5 cycles without cpu_gnt.
REQ-029 Contention, MEM_ARB_ROUND_ROBIN_EN build: both req high for 4 cycles -> DBG,CPU,DBG,CPU.
REQ-030 Interleaved: DBG read 8'h30 at N, CPU write 8'h31 data 8'h7E at N+1 -> dbg_rvalid=1 at N+1 with mem_rdata; mem_we=1, mem_wdata=8'h7E at N+1; no cpu_rvalid.
REQ-031 Reset mid-read: CPU read accepted at N, rst=0 at N+1 edge -> cpu_rvalid=0 at N+1; all outputs 0 while rst=0; first request after release is granted the same cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/debug memory arbiter with zero-latency grant and routed read return.
// Build option: MEM_ARB_ROUND_ROBIN_EN replaces fixed DBG priority and starvation guard with round-robin.
module mem_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpu_req,
   input  logic       cpu_we,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic       cpu_gnt,
   output logic       cpu_stall,
   output logic       cpu_rvalid,
   output logic [7:0] cpu_rdata,
   input  logic       dbg_req,
   input  logic       dbg_we,
   input  logic [7:0] dbg_addr,
   input  logic [7:0] dbg_wdata,
   output logic       dbg_gnt,
   output logic       dbg_rvalid,
   output logic [7:0] dbg_rdata,
   output logic       mem_en,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata
);

   typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_DBG} owner_t;

   owner_t r_owner;
   owner_t w_owner_nxt;
   logic   r_rd_pend;
   logic   w_pick_cpu;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Set when CPU won the most recent contested cycle; reset value makes DBG win first.
   logic r_rr_last_cpu;

   always_ff @(posedge clk) begin
      if (!rst)
         r_rr_last_cpu <= 1'b1;
      else if (cpu_req && dbg_req)
         r_rr_last_cpu <= w_pick_cpu;
   end

   assign w_pick_cpu = !r_rr_last_cpu;
`else
   // r_burst counts contested DBG wins; the win seen at count 3 arms r_force_cpu for the next contest.
   logic [1:0] r_burst;
   logic       r_force_cpu;

   always_ff @(posedge clk) begin
      if (!rst || !cpu_req || cpu_gnt) begin
         r_burst     <= 2'd0;
         r_force_cpu <= 1'b0;
      end else if (dbg_gnt) begin
         if (r_burst == 2'd3)
            r_force_cpu <= 1'b1;
         else
            r_burst <= r_burst + 2'd1;
      end
   end

   assign w_pick_cpu = r_force_cpu;
`endif

   always_comb begin
      cpu_gnt     = 1'b0;
      dbg_gnt     = 1'b0;
      w_owner_nxt = OWN_IDLE;
      if (rst) begin
         if (cpu_req && dbg_req) begin
            cpu_gnt = w_pick_cpu;
            dbg_gnt = !w_pick_cpu;
         end else begin
            cpu_gnt = cpu_req;
            dbg_gnt = dbg_req;
         end
      end
      if (cpu_gnt)
         w_owner_nxt = OWN_CPU;
      else if (dbg_gnt)
         w_owner_nxt = OWN_DBG;
   end

   // The owner register doubles as the read-return router: it names last cycle's winner.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_owner   <= OWN_IDLE;
         r_rd_pend <= 1'b0;
      end else begin
         r_owner   <= w_owner_nxt;
         r_rd_pend <= mem_en && !mem_we;
      end
   end

   assign cpu_stall  = rst && cpu_req && !cpu_gnt;
   assign mem_en     = cpu_gnt || dbg_gnt;
   assign mem_we     = cpu_gnt ? cpu_we    : (dbg_gnt ? dbg_we    : 1'b0);
   assign mem_addr   = cpu_gnt ? cpu_addr  : (dbg_gnt ? dbg_addr  : 8'h00);
   assign mem_wdata  = cpu_gnt ? cpu_wdata : (dbg_gnt ? dbg_wdata : 8'h00);

   assign cpu_rvalid = rst && r_rd_pend && (r_owner == OWN_CPU);
   assign dbg_rvalid = rst && r_rd_pend && (r_owner == OWN_DBG);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : 8'h00;
   assign dbg_rdata  = dbg_rvalid ? mem_rdata : 8'h00;

endmodule
